// File: rtl/camera_pkg.sv
// Shared encodings and helpers for the DVP camera capture path.
package camera_pkg;

  localparam logic [1:0] MODE_RGB565 = 2'd0;
  localparam logic [1:0] MODE_RGB444 = 2'd1;
  localparam logic [1:0] MODE_RAW8   = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_VS,
    ST_BLANK,
    ST_ACTIVE
  } cap_state_e;

  // Repeat the src_w-bit value (held in value[src_w-1:0]) MSB-first to fill ch_w bits, right-aligned.
  function automatic logic [15:0] ch_expand(input logic [7:0] value, input int src_w, input int ch_w);
    logic [15:0] res;
    res = '0;
    for (int i = 0; i < 16; i++)
      if (i < ch_w) res[4'(ch_w - 1 - i)] = value[3'(src_w - 1 - (i % src_w))];
    return res;
  endfunction

endpackage

// File: rtl/dvp_sync_tracker.sv
// Registers the DVP inputs and tracks frame structure; emits frame/line strobes.
module dvp_sync_tracker
  import camera_pkg::*;
#(
  parameter logic VSYNC_POL = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       vsync,
  input  logic       href,
  input  logic [7:0] pdata,
  output cap_state_e state,
  output logic       href_q,
  output logic [7:0] pdata_q,
  output logic       frame_start,
  output logic       frame_end,
  output logic       line_end
);

  logic vsync_q, href_qq, in_blank;

  assign in_blank = (vsync_q == VSYNC_POL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      vsync_q <= 1'b0;
      href_q  <= 1'b0;
      href_qq <= 1'b0;
      pdata_q <= '0;
    end else begin
      vsync_q <= vsync;
      href_q  <= href;
      href_qq <= href_q;
      pdata_q <= pdata;
      if (!enable) state <= ST_IDLE;
      else begin
        case (state)
          ST_IDLE:    state <= ST_WAIT_VS;
          ST_WAIT_VS: if (in_blank) state <= ST_BLANK;
          ST_BLANK:   if (!in_blank) state <= ST_ACTIVE;
          ST_ACTIVE:  if (in_blank) state <= ST_BLANK;
          default:    state <= ST_IDLE;
        endcase
      end
    end
  end

  // Strobes decode the cycle in which the state register is about to change.
  assign frame_start = enable && (state == ST_BLANK) && !in_blank;
  assign frame_end   = enable && (state == ST_ACTIVE) && in_blank;
  assign line_end    = (state == ST_ACTIVE) && href_qq && !href_q;

endmodule

// File: rtl/dvp_pixel_capture.sv
// DVP capture front end: unpacks sensor bytes into {R,G,B} pixels with coordinates and error tracking.
module dvp_pixel_capture
  import camera_pkg::*;
#(
  parameter int   H_ACT     = 1280,
  parameter int   V_ACT     = 720,
  parameter int   CH_W      = 8,
  parameter logic VSYNC_POL = 1'b1,
  localparam int  XW        = $clog2(H_ACT + 1),
  localparam int  YW        = $clog2(V_ACT + 1)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_enable,
  input  logic [1:0]        i_mode,
  input  logic              i_vsync,
  input  logic              i_href,
  input  logic [7:0]        i_pdata,
  input  logic              i_full,
  input  logic              i_clr_err,
  output logic [3*CH_W-1:0] o_rgb,
  output logic              o_valid,
  output logic              o_sof,
  output logic              o_eol,
  output logic [XW-1:0]     o_x,
  output logic [YW-1:0]     o_y,
  output logic [15:0]       o_frame_cnt,
  output logic [15:0]       o_drop_cnt,
  output logic              o_line_err,
  output logic              o_frame_err
);

  localparam logic [XW-1:0] X_MAX  = XW'(H_ACT);
  localparam logic [XW-1:0] X_LAST = XW'(H_ACT - 1);
  localparam logic [YW-1:0] Y_MAX  = YW'(V_ACT);

  cap_state_e      state;
  logic            href_q, frame_start, frame_end, line_end;
  logic [7:0]      pdata_q, byte0;
  logic [1:0]      mode;
  logic            phase, sof_pend, line_ovf, frame_ovf;
  logic [XW-1:0]   x;
  logic [YW-1:0]   y;
  logic            pix_done, in_range, line_err_set, frame_err_set;
  logic [CH_W-1:0] r, g, b;

  dvp_sync_tracker #(.VSYNC_POL(VSYNC_POL)) u_sync (
    .clk(i_clk), .rst(i_rst), .enable(i_enable),
    .vsync(i_vsync), .href(i_href), .pdata(i_pdata),
    .state(state), .href_q(href_q), .pdata_q(pdata_q),
    .frame_start(frame_start), .frame_end(frame_end), .line_end(line_end)
  );

  always_comb begin
    r = CH_W'(ch_expand({3'b0, byte0[7:3]}, 5, CH_W));
    g = CH_W'(ch_expand({2'b0, byte0[2:0], pdata_q[7:5]}, 6, CH_W));
    b = CH_W'(ch_expand({3'b0, pdata_q[4:0]}, 5, CH_W));
    case (mode)
      MODE_RGB444: begin
        r = CH_W'(ch_expand({4'b0, byte0[3:0]}, 4, CH_W));
        g = CH_W'(ch_expand({4'b0, pdata_q[7:4]}, 4, CH_W));
        b = CH_W'(ch_expand({4'b0, pdata_q[3:0]}, 4, CH_W));
      end
      MODE_RAW8: begin
        r = CH_W'(ch_expand(pdata_q, 8, CH_W));
        g = r;
        b = r;
      end
      default: ;
    endcase
  end

  assign pix_done = (state == ST_ACTIVE) && href_q && (mode == MODE_RAW8 || phase);
  assign in_range = (x < X_MAX) && (y < Y_MAX);
  // Overflow bits catch lines/frames longer than nominal even though x/y saturate.
  assign line_err_set  = i_enable && line_end && (phase || x != X_MAX || line_ovf);
  assign frame_err_set = i_enable && frame_end && (y != Y_MAX || frame_ovf);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_rgb <= '0; o_valid <= 1'b0; o_sof <= 1'b0; o_eol <= 1'b0;
      o_x <= '0; o_y <= '0; o_frame_cnt <= '0; o_drop_cnt <= '0;
      o_line_err <= 1'b0; o_frame_err <= 1'b0;
      byte0 <= '0; mode <= MODE_RGB565; phase <= 1'b0; sof_pend <= 1'b0;
      line_ovf <= 1'b0; frame_ovf <= 1'b0; x <= '0; y <= '0;
    end else begin
      o_valid     <= 1'b0;
      o_line_err  <= line_err_set | (o_line_err & ~i_clr_err);
      o_frame_err <= frame_err_set | (o_frame_err & ~i_clr_err);
      if (!i_enable) begin
        phase <= 1'b0; sof_pend <= 1'b0; line_ovf <= 1'b0; frame_ovf <= 1'b0;
        x <= '0; y <= '0;
      end else begin
        if (frame_start) begin
          mode <= i_mode; sof_pend <= 1'b1; line_ovf <= 1'b0; frame_ovf <= 1'b0;
          x <= '0; y <= '0;
        end
        if (state == ST_ACTIVE && href_q) begin
          if (mode != MODE_RAW8) phase <= ~phase;
          if (!phase) byte0 <= pdata_q;
        end else phase <= 1'b0;
        if (pix_done) begin
          if (in_range) begin
            sof_pend <= 1'b0;
            if (i_full) begin
              if (o_drop_cnt != 16'hFFFF) o_drop_cnt <= o_drop_cnt + 16'd1;
            end else begin
              o_valid <= 1'b1; o_rgb <= {r, g, b}; o_x <= x; o_y <= y;
              o_sof <= sof_pend; o_eol <= (x == X_LAST);
            end
          end
          if (x == X_MAX) line_ovf <= 1'b1;
          else x <= x + 1'b1;
        end
        if (line_end) begin
          x <= '0; line_ovf <= 1'b0;
          if (y == Y_MAX) frame_ovf <= 1'b1;
          else y <= y + 1'b1;
        end
        if (frame_end) begin
          x <= '0; y <= '0; frame_ovf <= 1'b0;
          o_frame_cnt <= o_frame_cnt + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_dvp_pixel_capture.sv
// Directed bench for dvp_pixel_capture: two instances (CH_W 8 and 10) share one DVP stimulus stream.
module tb_dvp_pixel_capture;

  localparam int H = 4, V = 2;

  logic clk = 1'b0;
  logic rst, en, vs, hr, full, clr;
  logic [1:0] mode;
  logic [7:0] pd;
  logic [23:0] rgb8;
  logic [29:0] rgb10;
  logic v8, v10, sof8, sof10, eol8, eol10, le8, le10, fe8, fe10;
  logic [2:0] x8, x10;
  logic [1:0] y8, y10;
  logic [15:0] fc8, fc10, dc8, dc10;

  always #5 clk = ~clk;

  dvp_pixel_capture #(.H_ACT(H), .V_ACT(V), .CH_W(8), .VSYNC_POL(1'b1)) u8 (
    .i_clk(clk), .i_rst(rst), .i_enable(en), .i_mode(mode), .i_vsync(vs), .i_href(hr),
    .i_pdata(pd), .i_full(full), .i_clr_err(clr), .o_rgb(rgb8), .o_valid(v8), .o_sof(sof8),
    .o_eol(eol8), .o_x(x8), .o_y(y8), .o_frame_cnt(fc8), .o_drop_cnt(dc8),
    .o_line_err(le8), .o_frame_err(fe8));

  dvp_pixel_capture #(.H_ACT(H), .V_ACT(V), .CH_W(10), .VSYNC_POL(1'b1)) u10 (
    .i_clk(clk), .i_rst(rst), .i_enable(en), .i_mode(mode), .i_vsync(vs), .i_href(hr),
    .i_pdata(pd), .i_full(full), .i_clr_err(clr), .o_rgb(rgb10), .o_valid(v10), .o_sof(sof10),
    .o_eol(eol10), .o_x(x10), .o_y(y10), .o_frame_cnt(fc10), .o_drop_cnt(dc10),
    .o_line_err(le10), .o_frame_err(fe10));

  typedef struct {
    logic [29:0] rgb;
    logic [2:0]  x;
    logic [1:0]  y;
    logic        sof;
    logic        eol;
    int          cyc;
  } pix_t;

  pix_t q8[$], q10[$];
  int cyc = 0, checks = 0, errors = 0, t0 = 0;
  logic [7:0] lb [8];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (v8)  q8.push_back('{rgb: {6'd0, rgb8}, x: x8, y: y8, sof: sof8, eol: eol8, cyc: cyc});
    if (v10) q10.push_back('{rgb: rgb10, x: x10, y: y10, sof: sof10, eol: eol10, cyc: cyc});
  end

  task automatic step(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_pix(input string tag, input bit use10, input int idx, input logic [29:0] rgb,
                         input int x, input int y, input logic sof, input logic eol);
    pix_t p;
    int n;
    n = use10 ? q10.size() : q8.size();
    chk({tag, ".present"}, 48'(n > idx), 48'd1);
    if (n > idx) p = use10 ? q10[idx] : q8[idx];
    else p = '{rgb: 'x, x: 'x, y: 'x, sof: 1'bx, eol: 1'bx, cyc: -1};
    chk({tag, ".rgb"}, 48'(p.rgb), 48'(rgb));
    chk({tag, ".xy"}, {43'd0, p.x, p.y}, {43'd0, 3'(x), 2'(y)});
    chk({tag, ".sof_eol"}, {46'd0, p.sof, p.eol}, {46'd0, sof, eol});
  endtask

  task automatic send_line(input int n, input int nfull, input bit clr_end);
    hr = 1'b1;
    for (int i = 0; i < n; i++) begin
      pd = lb[i]; full = (i < nfull);
      if (i == 0) t0 = cyc;
      step();
    end
    hr = 1'b0; full = 1'b0; pd = 8'h00;
    step();
    if (clr_end) begin clr = 1'b1; step(); clr = 1'b0; end
  endtask

  task automatic vs_on();  vs = 1'b1; step(4); endtask
  task automatic vs_off(); vs = 1'b0; step(3); endtask

  initial begin
    rst = 1'b1; en = 1'b0; vs = 1'b0; hr = 1'b0; pd = 8'h00; mode = 2'd0; full = 1'b0; clr = 1'b0;
    step(2);
    chk("reset.flags", {43'd0, v8, sof8, eol8, le8, fe8}, 48'd0);
    chk("reset.xy", {43'd0, x8, y8}, 48'd0);
    chk("reset.cnts", {16'd0, fc8, dc8}, 48'd0);
    chk("reset.rgb", 48'(rgb8), 48'd0);
    rst = 1'b0; step(); en = 1'b1; step(2);

    // Frame A: RGB565 primaries
    vs_on(); vs_off();
    lb = '{8'hF8, 8'h00, 8'h07, 8'hE0, 8'h00, 8'h1F, 8'h00, 8'h00};
    send_line(8, 0, 0); send_line(8, 0, 0); step(2);
    chk("A.count", 48'(q8.size()), 48'd8);
    chk_pix("A.p0", 0, 0, 30'hFF0000, 0, 0, 1'b1, 1'b0);
    chk_pix("A.p1", 0, 1, 30'h00FF00, 1, 0, 1'b0, 1'b0);
    chk_pix("A.p2", 0, 2, 30'h0000FF, 2, 0, 1'b0, 1'b0);
    chk_pix("A.p3", 0, 3, 30'h000000, 3, 0, 1'b0, 1'b1);
    chk_pix("A.p4", 0, 4, 30'hFF0000, 0, 1, 1'b0, 1'b0);
    chk("A.line_err", 48'(le8), 48'd0);
    mode = 2'd2;
    vs_on();
    chk("A.frame_cnt", 48'(fc8), 48'd1);
    chk("A.frame_err", 48'(fe8), 48'd0);
    vs_off();

    // Frame B: RAW8, one pixel per clock
    q8.delete(); q10.delete();
    lb = '{8'hA5, 8'h3C, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    send_line(4, 0, 0); step(2);
    chk("B.count", 48'(q10.size()), 48'd4);
    chk_pix("B.p0", 1, 0, 30'h296A5A96, 0, 0, 1'b1, 1'b0);
    chk_pix("B.p2", 1, 2, 30'h3FFFFFFF, 2, 0, 1'b0, 1'b0);
    chk_pix("B.p3", 1, 3, 30'h0, 3, 0, 1'b0, 1'b1);
    chk_pix("B.p0_w8", 0, 0, 30'hA5A5A5, 0, 0, 1'b1, 1'b0);
    if (q10.size() >= 2) begin
      chk("B.latency", 48'(q10[0].cyc - t0), 48'd2);
      chk("B.rate", 48'(q10[1].cyc - q10[0].cyc), 48'd1);
    end
    send_line(4, 0, 0); step(2);
    mode = 2'd0;
    vs_on();
    chk("B.frame_cnt", 48'(fc8), 48'd2);
    vs_off();

    // Frame C: short RGB565 lines and error clearing
    lb = '{8'hF8, 8'h00, 8'h07, 8'hE0, 8'h00, 8'h1F, 8'h00, 8'h00};
    send_line(7, 0, 0); step(2);
    chk("C.line_err_set", 48'(le8), 48'd1);
    clr = 1'b1; step(); clr = 1'b0; step();
    chk("C.line_err_clr", 48'(le8), 48'd0);
    send_line(7, 0, 1); step(2);
    chk("C.set_dominant", 48'(le8), 48'd1);
    clr = 1'b1; step(); clr = 1'b0; step();
    mode = 2'd1;
    vs_on();
    chk("C.frame_cnt", 48'(fc8), 48'd3);
    chk("C.frame_err", 48'(fe8), 48'd0);
    vs_off();

    // Frame D: RGB444, only one line so the frame is short
    q8.delete();
    lb = '{8'h0A, 8'h5F, 8'h0F, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    send_line(8, 0, 0); step(2);
    chk_pix("D.p0", 0, 0, 30'hAA55FF, 0, 0, 1'b1, 1'b0);
    chk_pix("D.p1", 0, 1, 30'hFF0000, 1, 0, 1'b0, 1'b0);
    mode = 2'd0;
    vs_on();
    chk("D.frame_cnt", 48'(fc8), 48'd4);
    chk("D.frame_err", 48'(fe8), 48'd1);
    vs_off();

    // Frame E: three pixels dropped while full
    q8.delete();
    lb = '{8'hF8, 8'h00, 8'h07, 8'hE0, 8'h00, 8'h1F, 8'h00, 8'h1F};
    send_line(8, 8, 0); step(2);
    chk("E.count", 48'(q8.size()), 48'd1);
    chk_pix("E.after_drop", 0, 0, 30'h0000FF, 3, 0, 1'b0, 1'b1);
    chk("E.drop_cnt", 48'(dc8), 48'd3);
    send_line(8, 0, 0); step(2);
    chk_pix("E.line1", 0, 1, 30'hFF0000, 0, 1, 1'b0, 1'b0);
    vs_on();
    chk("E.frame_cnt", 48'(fc8), 48'd5);
    chk("E.u10_stat", {fc10, dc10, 14'd0, le10, fe10}, {16'd5, 16'd3, 14'd0, 1'b0, 1'b1});
    vs_off();

    // Frame F: enable dropped mid-line, raised mid-frame
    hr = 1'b1;
    for (int i = 0; i < 4; i++) begin pd = lb[i]; step(); end
    en = 1'b0;
    for (int i = 4; i < 8; i++) begin pd = lb[i]; step(); end
    hr = 1'b0; step(3);
    q8.delete();
    en = 1'b1; step(2);
    send_line(8, 0, 0); send_line(8, 0, 0); step(2);
    chk("F.no_output", 48'(q8.size()), 48'd0);
    vs_on();
    chk("F.no_frame_count", 48'(fc8), 48'd5);
    vs_off();
    send_line(8, 0, 0); step(2);
    chk_pix("F.resume", 0, 0, 30'hFF0000, 0, 0, 1'b1, 1'b0);

    // Frame G: reset mid-line
    hr = 1'b1;
    for (int i = 0; i < 4; i++) begin pd = lb[i]; step(); end
    rst = 1'b1; step();
    q8.delete();
    chk("G.flags", {43'd0, v8, sof8, eol8, le8, fe8}, 48'd0);
    chk("G.xy", {43'd0, x8, y8}, 48'd0);
    chk("G.cnts", {16'd0, fc8, dc8}, 48'd0);
    chk("G.rgb", 48'(rgb8), 48'd0);
    rst = 1'b0;
    for (int i = 4; i < 8; i++) begin pd = lb[i]; step(); end
    hr = 1'b0; step();
    send_line(8, 0, 0); step(2);
    chk("G.no_output", 48'(q8.size()), 48'd0);
    vs_on();
    chk("G.frame_cnt", 48'(fc8), 48'd0);
    vs_off();
    send_line(8, 0, 0); step(2);
    chk_pix("G.resume", 0, 0, 30'hFF0000, 0, 0, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
